// File: rtl/cache_data_array_if.sv
// Request, read-return and refill signals between the cache controller and the data array.
// The controller drives the master side; the array implements the slave side.
interface cache_data_array_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int CHAN_WIDTH  = 3,
  parameter int DATA_WIDTH  = 128,
  parameter int BEAT_WIDTH  = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wr;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [CHAN_WIDTH-1:0]     req_chan;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      rd_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_perr;
  logic                      fill_start;
  logic [INDEX_WIDTH-1:0]    fill_index;
  logic [CHAN_WIDTH-1:0]     fill_chan;
  logic                      fill_beat_valid;
  logic [BEAT_WIDTH-1:0]     fill_beat_data;
  logic                      fill_done;
  logic                      busy;

  modport master (
    output req_valid, req_wr, req_index, req_chan, req_wdata, req_be,
    output fill_start, fill_index, fill_chan, fill_beat_valid, fill_beat_data,
    input  req_ready, rd_valid, rd_data, rd_perr, fill_done, busy
  );

  modport slave (
    input  req_valid, req_wr, req_index, req_chan, req_wdata, req_be,
    input  fill_start, fill_index, fill_chan, fill_beat_valid, fill_beat_data,
    output req_ready, rd_valid, rd_data, rd_perr, fill_done, busy
  );
endinterface

// File: rtl/cache_data_array.sv
// Cache data store: CPU byte-enable reads/writes plus a beat-serial refill path, addressed by {chan,index}.
// Optional per-byte even parity is enabled by defining DATA_MEM_PARITY_EN.
module cache_data_array #(
  parameter int INDEX_WIDTH = 4,
  parameter int CHAN_WIDTH  = 3,
  parameter int DATA_WIDTH  = 128,
  parameter int BEAT_WIDTH  = 32
) (
  input logic               clk,
  input logic               rsta,
  cache_data_array_if.slave bus
);
  localparam int NBEATS     = DATA_WIDTH / BEAT_WIDTH;
  localparam int NBYTES     = DATA_WIDTH / 8;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int CNT_W      = $clog2(NBEATS);
  localparam int ADDR_W     = CHAN_WIDTH + INDEX_WIDTH;
  localparam int NLINES     = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

  state_t                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
  logic [ADDR_W-1:0]       fill_addr_r, fill_addr_nx_s;
  logic                    fill_done_r, fill_done_nx_s;
  logic                    rd_valid_r, rd_perr_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    req_ready_s, fill_wr_s, rd_en_s, cpu_wr_s, perr_s;
  logic [ADDR_W-1:0]       req_addr_s, wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_line_s;
  logic [NBYTES-1:0]       wr_be_s;

  logic [DATA_WIDTH-1:0]   mem [NLINES];

`ifdef DATA_MEM_PARITY_EN
  logic [NBYTES-1:0]       par_mem [NLINES];

  function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NBYTES-1:0] p;
    for (int i = 0; i < NBYTES; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction
`endif

  // FSM next-state: request gating and refill beat sequencing
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    fill_addr_nx_s = fill_addr_r;
    fill_done_nx_s = 1'b0;
    req_ready_s    = 1'b0;
    fill_wr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = !bus.fill_start;
        if (bus.fill_start) begin
          state_nx_s     = ST_FILL;
          cnt_nx_s       = {CNT_W{1'b0}};
          fill_addr_nx_s = {bus.fill_chan, bus.fill_index};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (bus.fill_beat_valid) begin
          fill_wr_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nx_s     = ST_IDLE;
            cnt_nx_s       = {CNT_W{1'b0}};
            fill_done_nx_s = 1'b1;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Write-port mux: a refill beat lands in its slot of the line, a CPU write uses its byte enables
  always_comb begin
    req_addr_s = {bus.req_chan, bus.req_index};
    rd_en_s    = bus.req_valid & req_ready_s & !bus.req_wr;
    cpu_wr_s   = bus.req_valid & req_ready_s & bus.req_wr;
    wr_be_s    = {NBYTES{1'b0}};
    if (fill_wr_s) begin
      wr_addr_s = fill_addr_r;
      wr_line_s = {NBEATS{bus.fill_beat_data}};
      for (int i = 0; i < NBYTES; i++) begin
        wr_be_s[i] = (CNT_W'(i / BEAT_BYTES) == cnt_r);
      end
    end else begin
      wr_addr_s = req_addr_s;
      wr_line_s = bus.req_wdata;
      wr_be_s   = cpu_wr_s ? bus.req_be : {NBYTES{1'b0}};
    end
  end

  // Read-side parity check of the stored line
  always_comb begin
`ifdef DATA_MEM_PARITY_EN
    perr_s = |(par_mem[req_addr_s] ^ byte_parity(mem[req_addr_s]));
`else
    perr_s = 1'b0;
`endif
  end

  // Array storage is never reset; contents survive rsta
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be_s[i]) begin
        mem[wr_addr_s][8*i +: 8] <= wr_line_s[8*i +: 8];
`ifdef DATA_MEM_PARITY_EN
        par_mem[wr_addr_s][i]    <= ^wr_line_s[8*i +: 8];
`endif
      end
    end
  end

  // State, beat counter and registered outputs
  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      fill_addr_r <= {ADDR_W{1'b0}};
      fill_done_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      rd_perr_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      fill_addr_r <= fill_addr_nx_s;
      fill_done_r <= fill_done_nx_s;
      rd_valid_r  <= rd_en_s;
      if (rd_en_s) begin
        rd_data_r <= mem[req_addr_s];
        rd_perr_r <= perr_s;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.busy      = (state_r == ST_FILL);
  assign bus.fill_done = fill_done_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_perr   = rd_perr_r;
endmodule
